// File: rtl/demux_pkg.sv
// Shared constants, channel state encoding and slice helper for the 1-to-4 buffered demux.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  // Bit offset of channel ch inside a packed NUM_CH*width bus.
  function automatic int ch_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry buffer with EMPTY/FULL FSM and valid/ack handshake.
// With DEMUX_COUNT_EN defined, also keeps a wrapping count of completed reads.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
  , output logic [CNT_W-1:0] count
`endif
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             read_fire;

  assign read_fire = ack & (state_q == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A write in the same cycle as a read keeps the slot FULL with the new word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_en) begin
      state_d = FULL;
      data_d  = wr_data;
    end else if (read_fire) begin
      state_d = EMPTY;
    end
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (read_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign count = cnt_q;
`endif

endmodule

// File: rtl/demux_4_buf.sv
// Registered 1-to-4 demultiplexer with a one-word valid/ack buffer per channel.
// Optional per-channel delivery counters on out_count when DEMUX_COUNT_EN is defined.
module demux_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        select,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ack,
  output logic                    drop_err
`ifdef DEMUX_COUNT_EN
  , output logic [NUM_CH*CNT_W-1:0] out_count
`endif
);

  logic              wr_fire;
  logic [NUM_CH-1:0] wr_en;
  logic              drop_err_q, drop_err_d;

  // Ready depends only on the selected slot, never on in_valid.
  assign in_ready = ~out_valid[select] | out_ack[select];
  assign wr_fire  = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign wr_en[gi] = wr_fire & (select == SEL_W'(gi));

      demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
        , .CNT_W (CNT_W)
`endif
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[gi]),
        .wr_data (in_data),
        .ack     (out_ack[gi]),
        .valid   (out_valid[gi]),
        .data    (out_data[ch_offset(gi, WIDTH) +: WIDTH])
`ifdef DEMUX_COUNT_EN
        , .count (out_count[ch_offset(gi, CNT_W) +: CNT_W])
`endif
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= drop_err_d;
    end
  end

  // Sticky: any ack presented to an empty channel.
  always_comb begin
    drop_err_d = drop_err_q | (|(out_ack & ~out_valid));
  end

  assign drop_err = drop_err_q;

endmodule
